// File: rtl/aoc_ctrl_pkg.sv
// Shared types and constants for the AoC job controller: state encoding,
// header field layout and error frame construction.
package aoc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CLEAR       = 3'd1,
    STREAM      = 3'd2,
    WAIT_RESULT = 3'd3,
    SEND        = 3'd4,
    ERR_SEND    = 3'd5
  } state_e;

  localparam int FRAME_W = 64;

  localparam logic [15:0] HDR_MAGIC     = 16'hA0C5;
  localparam logic [15:0] ERR_MARK      = 16'hEEEE;
  localparam logic [7:0]  ERR_BAD_MAGIC = 8'd1;
  localparam logic [7:0]  ERR_OVERFLOW  = 8'd2;
  localparam logic [7:0]  ERR_TIMEOUT   = 8'd3;

  localparam int HDR_MAGIC_MSB = 63;
  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_PUZ_MSB   = 47;
  localparam int HDR_PUZ_LSB   = 43;
  localparam int HDR_N_MSB     = 31;
  localparam int HDR_N_LSB     = 0;

  function automatic logic [FRAME_W-1:0] err_frame(input logic [7:0]  code,
                                                   input logic [31:0] fwd_cnt);
    return {ERR_MARK, code, 8'h00, fwd_cnt};
  endfunction

endpackage

// File: rtl/aoc_frame_fifo.sv
// Data-frame buffer between the UART receive side and the solver stream.
// Show-ahead read: dout is the head entry whenever empty is low.
module aoc_frame_fifo
  import aoc_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [FRAME_W-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [FRAME_W-1:0] dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q;
  logic               do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only taken when a pop frees the head slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/aoc_job_controller.sv
// Runs one puzzle job at a time on aoc_top: header decode, core clear, data
// streaming over valid/ready, result capture and response/error frame send.
module aoc_job_controller
  import aoc_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_valid,
  input  logic [63:0] frame_data,
  output logic        aoc_clear,
  output logic [4:0]  puzzle,
  output logic [63:0] data_value,
  output logic        data_valid,
  input  logic        data_ready,
  input  logic        result_valid,
  input  logic [63:0] result_value,
  input  logic        tx_ready,
  output logic        tx_send,
  output logic [63:0] tx_data,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] clr_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [31:0]   n_q, pushed_q, fwd_q;
  logic [4:0]    puzzle_q;
  logic          dv_q, aoc_clear_q, tx_send_q, rv_prev_q;
  logic [63:0]   dval_q, tx_data_q;

  logic          fifo_full, fifo_empty, push, pop, hs, overflow, to_idle, rv_rise;
  logic [63:0]   fifo_dout;
  logic          hdr_unused;

  assign hdr_unused = ^frame_data[HDR_PUZ_LSB-1:HDR_N_MSB+1];

  assign hs       = dv_q && data_ready;
  assign push     = frame_valid && (state_q == CLEAR || state_q == STREAM) && (pushed_q < n_q);
  assign pop      = (state_q == STREAM) && !fifo_empty && (!dv_q || data_ready);
  assign overflow = push && fifo_full && !pop;
  assign rv_rise  = result_valid && !rv_prev_q;
  assign to_idle  = (state_q == SEND || state_q == ERR_SEND) && tx_send_q;

  aoc_frame_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push && !overflow),
    .pop     (pop),
    .flush   (to_idle),
    .din     (frame_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dout    (fifo_dout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      to_cnt_q    <= '0;
      n_q         <= '0;
      pushed_q    <= '0;
      fwd_q       <= '0;
      puzzle_q    <= '0;
      dv_q        <= 1'b0;
      dval_q      <= '0;
      aoc_clear_q <= 1'b0;
      tx_send_q   <= 1'b0;
      tx_data_q   <= '0;
      rv_prev_q   <= 1'b0;
    end else begin
      rv_prev_q <= result_valid;
      tx_send_q <= 1'b0;
      if (hs) begin
        dv_q  <= 1'b0;
        fwd_q <= fwd_q + 32'd1;
      end
      if (pop) begin
        dv_q   <= 1'b1;
        dval_q <= fifo_dout;
      end
      if (push) pushed_q <= pushed_q + 32'd1;

      case (state_q)
        IDLE: begin
          if (frame_valid) begin
            if (frame_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB] != HDR_MAGIC) begin
              tx_data_q <= err_frame(ERR_BAD_MAGIC, 32'd0);
              state_q   <= ERR_SEND;
            end else begin
              puzzle_q    <= frame_data[HDR_PUZ_MSB:HDR_PUZ_LSB];
              n_q         <= frame_data[HDR_N_MSB:HDR_N_LSB];
              pushed_q    <= '0;
              fwd_q       <= '0;
              clr_cnt_q   <= '0;
              aoc_clear_q <= 1'b1;
              // Re-armed here; CLEAR re-samples the level so a stale high never counts as an edge.
              rv_prev_q   <= 1'b0;
              state_q     <= CLEAR;
            end
          end
        end
        CLEAR: begin
          if (overflow) begin
            tx_data_q   <= err_frame(ERR_OVERFLOW, fwd_q);
            aoc_clear_q <= 1'b0;
            state_q     <= ERR_SEND;
          end else if (clr_cnt_q == CLR_LAST) begin
            aoc_clear_q <= 1'b0;
            to_cnt_q    <= '0;
            state_q     <= (n_q == 32'd0) ? WAIT_RESULT : STREAM;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        STREAM: begin
          if (overflow) begin
            tx_data_q <= err_frame(ERR_OVERFLOW, fwd_q + 32'(hs));
            dv_q      <= 1'b0;
            state_q   <= ERR_SEND;
          end else if (hs && (fwd_q + 32'd1 == n_q)) begin
            to_cnt_q <= '0;
            state_q  <= WAIT_RESULT;
          end
        end
        WAIT_RESULT: begin
          if (rv_rise) begin
            tx_data_q <= result_value;
            state_q   <= SEND;
          end else if (TIMEOUT_CYCLES > 0 && to_cnt_q == TO_LAST) begin
            tx_data_q <= err_frame(ERR_TIMEOUT, fwd_q);
            state_q   <= ERR_SEND;
          end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        SEND, ERR_SEND: begin
          // One cycle of tx_send, then back to IDLE on the following edge.
          if (tx_send_q) begin
            dv_q    <= 1'b0;
            state_q <= IDLE;
          end else if (tx_ready) begin
            tx_send_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign aoc_clear  = aoc_clear_q;
  assign puzzle     = puzzle_q;
  assign data_value = dval_q;
  assign data_valid = dv_q;
  assign tx_send    = tx_send_q;
  assign tx_data    = tx_data_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule
